// File: rtl/score_keeper.sv
// score_keeper: saturating score, hit streak, lives and IDLE/PLAY/WIN/LOSE
// game FSM fed by the note-hit judge's 2-bit point code.
// Optional feature macro: SCORE_COMBO_BONUS_EN (doubles positive gains once
// the streak before a tick has reached COMBO_LEN).
// The score-changed pulse is named score_event because "event" is a reserved
// word in SystemVerilog.
module score_keeper #(
    parameter int unsigned SCORE_W   = 10,
    parameter int unsigned TARGET    = 100,
    parameter int unsigned LIVES     = 3,
    parameter int unsigned LIVES_W   = 2,
    parameter int unsigned COMBO_W   = 4,
    parameter int unsigned COMBO_LEN = 4
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               tick,
    input  logic [1:0]         point,
    input  logic               start,
    output logic [SCORE_W-1:0] score,
    output logic [COMBO_W-1:0] combo,
    output logic [LIVES_W-1:0] lives,
    output logic [1:0]         state,
    output logic               stop,
    output logic               score_event
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        WIN  = 2'b10,
        LOSE = 2'b11
    } state_t;

`ifdef SCORE_COMBO_BONUS_EN
    localparam logic BONUS_EN = 1'b1;
`else
    localparam logic BONUS_EN = 1'b0;
`endif

    localparam logic [SCORE_W:0]   TARGET_V  = (SCORE_W+1)'(TARGET);
    localparam logic [COMBO_W-1:0] COMBO_THR = COMBO_W'(COMBO_LEN);
    localparam logic [LIVES_W-1:0] LIVES_V   = LIVES_W'(LIVES);

    state_t             state_q;
    logic               bonus;
    logic [2:0]         gain;
    logic [SCORE_W:0]   sum;
    logic [SCORE_W-1:0] score_upd;
    logic [COMBO_W-1:0] combo_upd;
    logic [LIVES_W-1:0] lives_upd;

    assign state = state_q;

    // Counter values that one PLAY tick would produce from the current point code
    always_comb begin
        bonus     = BONUS_EN && (combo >= COMBO_THR);
        gain      = 3'd0;
        score_upd = score;
        combo_upd = combo;
        lives_upd = lives;
        case (point)
            2'b01:   gain = bonus ? 3'd2 : 3'd1;
            2'b10:   gain = bonus ? 3'd4 : 3'd2;
            default: gain = 3'd0;
        endcase
        sum = {1'b0, score} + (SCORE_W+1)'(gain);
        case (point)
            2'b01, 2'b10: begin
                score_upd = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
                combo_upd = (combo == '1) ? combo : combo + COMBO_W'(1);
            end
            2'b11: begin
                score_upd = (score >= SCORE_W'(2)) ? score - SCORE_W'(2) : '0;
                combo_upd = '0;
                lives_upd = lives - LIVES_W'(1);
            end
            default: ;
        endcase
    end

    // Game FSM with registered counters, stop and score-changed pulse
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= IDLE;
            score       <= '0;
            combo       <= '0;
            lives       <= LIVES_V;
            stop        <= 1'b1;
            score_event <= 1'b0;
        end else begin
            score_event <= 1'b0;
            case (state_q)
                PLAY: begin
                    if (tick) begin
                        score       <= score_upd;
                        combo       <= combo_upd;
                        lives       <= lives_upd;
                        score_event <= (score_upd != score);
                        // A miss never raises the score, so LOSE and WIN are exclusive
                        if (lives_upd == '0) begin
                            state_q <= LOSE;
                            stop    <= 1'b1;
                        end else if ({1'b0, score_upd} >= TARGET_V) begin
                            state_q <= WIN;
                            stop    <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (start) begin
                        state_q <= PLAY;
                        stop    <= 1'b0;
                        score   <= '0;
                        combo   <= '0;
                        lives   <= LIVES_V;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// Directed self-checking bench for score_keeper (TARGET=6 so a win is reachable).
module tb_score_keeper;

    localparam int unsigned SCORE_W = 10;
    localparam int unsigned COMBO_W = 4;
    localparam int unsigned LIVES_W = 2;

    logic               Clock;
    logic               Reset;
    logic               tick;
    logic [1:0]         point;
    logic               start;
    logic [SCORE_W-1:0] score;
    logic [COMBO_W-1:0] combo;
    logic [LIVES_W-1:0] lives;
    logic [1:0]         state;
    logic               stop;
    logic               score_event;

    int n_assert = 0;
    int n_fail   = 0;
    int ev_cnt   = 0;

    score_keeper #(
        .SCORE_W(SCORE_W), .TARGET(6), .LIVES(3), .LIVES_W(LIVES_W),
        .COMBO_W(COMBO_W), .COMBO_LEN(4)
    ) dut (
        .Clock(Clock), .Reset(Reset), .tick(tick), .point(point), .start(start),
        .score(score), .combo(combo), .lives(lives), .state(state),
        .stop(stop), .score_event(score_event)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample #1 after the edge
    task automatic step(input logic t, input logic [1:0] p, input logic s);
        tick = t; point = p; start = s;
        @(posedge Clock);
        #1;
        tick = 1'b0; point = 2'b00; start = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        @(posedge Clock);
        @(posedge Clock);
        #1;
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; tick = 1'b0; point = 2'b00; start = 1'b0;
        do_reset();

        // Reset state
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_combo", 32'(combo), 32'd0);
        chk("rst_lives", 32'(lives), 32'd3);
        chk("rst_stop",  32'(stop),  32'd1);
        chk("rst_event", 32'(score_event), 32'd0);

        // Scoring: 10, 01, 10 -> 5
        step(1'b0, 2'b00, 1'b1);
        chk("start_state", 32'(state), 32'd1);
        chk("start_stop",  32'(stop),  32'd0);
        step(1'b1, 2'b10, 1'b0);
        chk("sc1_score", 32'(score), 32'd2);
        if (score_event) ev_cnt++;
        step(1'b1, 2'b01, 1'b0);
        chk("sc2_score", 32'(score), 32'd3);
        if (score_event) ev_cnt++;
        step(1'b1, 2'b10, 1'b0);
        if (score_event) ev_cnt++;
        chk("sc3_score", 32'(score), 32'd5);
        chk("sc3_combo", 32'(combo), 32'd3);
        chk("sc3_lives", 32'(lives), 32'd3);
        chk("sc3_state", 32'(state), 32'd1);
        chk("sc3_stop",  32'(stop),  32'd0);
        chk("sc_events", 32'(ev_cnt), 32'd3);

        // Tick 00 leaves everything alone
        step(1'b1, 2'b00, 1'b0);
        chk("t00_score", 32'(score), 32'd5);
        chk("t00_combo", 32'(combo), 32'd3);
        chk("t00_event", 32'(score_event), 32'd0);
        step(1'b0, 2'b00, 1'b0);
        chk("idle_cyc_event", 32'(score_event), 32'd0);

        // Floor and loss
        do_reset();
        step(1'b0, 2'b00, 1'b1);
        step(1'b1, 2'b01, 1'b0);
        chk("fl_pre_score", 32'(score), 32'd1);
        step(1'b1, 2'b11, 1'b0);
        chk("fl1_score", 32'(score), 32'd0);
        chk("fl1_combo", 32'(combo), 32'd0);
        chk("fl1_lives", 32'(lives), 32'd2);
        chk("fl1_event", 32'(score_event), 32'd1);
        step(1'b1, 2'b11, 1'b0);
        chk("fl2_lives", 32'(lives), 32'd1);
        chk("fl2_event", 32'(score_event), 32'd0);
        chk("fl2_state", 32'(state), 32'd1);
        step(1'b1, 2'b11, 1'b0);
        chk("fl3_lives", 32'(lives), 32'd0);
        chk("fl3_state", 32'(state), 32'd3);
        chk("fl3_stop",  32'(stop),  32'd1);
        chk("fl3_event", 32'(score_event), 32'd0);
        step(1'b1, 2'b10, 1'b0);
        chk("lose_score", 32'(score), 32'd0);
        chk("lose_combo", 32'(combo), 32'd0);
        chk("lose_state", 32'(state), 32'd3);

        // Win at TARGET=6, then restart from LOSE-independent WIN
        step(1'b0, 2'b00, 1'b1);
        chk("w_start_lives", 32'(lives), 32'd3);
        step(1'b1, 2'b10, 1'b0);
        step(1'b1, 2'b10, 1'b0);
        chk("w2_score", 32'(score), 32'd4);
        chk("w2_stop",  32'(stop),  32'd0);
        step(1'b1, 2'b10, 1'b0);
        chk("w3_score", 32'(score), 32'd6);
        chk("w3_state", 32'(state), 32'd2);
        chk("w3_stop",  32'(stop),  32'd1);
        step(1'b1, 2'b10, 1'b0);
        chk("win_frozen", 32'(score), 32'd6);
        step(1'b0, 2'b00, 1'b1);
        chk("rs_state", 32'(state), 32'd1);
        chk("rs_score", 32'(score), 32'd0);
        chk("rs_lives", 32'(lives), 32'd3);
        chk("rs_combo", 32'(combo), 32'd0);

        // Five ticks of 01 (bonus kicks in on the fifth when enabled)
        for (int i = 0; i < 5; i++) step(1'b1, 2'b01, 1'b0);
`ifdef SCORE_COMBO_BONUS_EN
        chk("bonus_score", 32'(score), 32'd6);
        chk("bonus_state", 32'(state), 32'd2);
`else
        chk("bonus_score", 32'(score), 32'd5);
        chk("bonus_state", 32'(state), 32'd1);
`endif
        chk("bonus_combo", 32'(combo), 32'd5);

        // Start and tick together in IDLE: tick ignored
        do_reset();
        step(1'b1, 2'b10, 1'b1);
        chk("ie_state", 32'(state), 32'd1);
        chk("ie_score", 32'(score), 32'd0);
        chk("ie_event", 32'(score_event), 32'd0);

        // Reset mid-game with a tick pending
        step(1'b1, 2'b10, 1'b0);
        chk("mg_score", 32'(score), 32'd2);
        Reset = 1'b1;
        step(1'b1, 2'b10, 1'b0);
        Reset = 1'b0;
        chk("mr_state", 32'(state), 32'd0);
        chk("mr_score", 32'(score), 32'd0);
        chk("mr_combo", 32'(combo), 32'd0);
        chk("mr_lives", 32'(lives), 32'd3);
        chk("mr_stop",  32'(stop),  32'd1);
        chk("mr_event", 32'(score_event), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
